id_exe_stage_reg: RTL and testbench

Pipeline register between the instruction-decode stage and the execute stage of the ARM core. It captures every decoded field, operand value and control bit on each rising clock edge, so that the execute stage (Val2 generation, ALU, branch-target adder) sees a stable, single-cycle-delayed instruction. It also supports stall (freeze) and squash (flush) for hazard handling and branches, and registers a derived load/store flag that the Val2 generator consumes directly.

---
 rtl/id_exe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register with freeze (stall) and flush (bubble) control.
// Define FORWARDING_EN to build the src1/src2 registers; otherwise src1_out/src2_out read 4'h0.
module id_exe_stage_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [3:0]  status_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn_out,
    output logic [31:0] val_rm_out,
    output logic        imm_out,
    output logic [11:0] shift_operand_out,
    output logic [23:0] signed_imm_24_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  exe_cmd_out,
    output logic [3:0]  status_out,
    output logic [3:0]  src1_out,
    output logic [3:0]  src2_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        b_out,
    output logic        s_out,
    output logic        is_ldr_or_str_out
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic [3:0]  status;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        is_ldr_or_str;
    } stage_t;

    stage_t r_stage;
    stage_t w_load;

    // Side-effecting control bits are gated so a non-valid slot is always harmless.
    always_comb begin
        w_load               = '0;
        w_load.valid         = valid_in;
        w_load.pc            = pc_in;
        w_load.val_rn        = val_rn_in;
        w_load.val_rm        = val_rm_in;
        w_load.imm           = imm_in;
        w_load.shift_operand = shift_operand_in;
        w_load.signed_imm_24 = signed_imm_24_in;
        w_load.dest          = dest_in;
        w_load.exe_cmd       = exe_cmd_in;
        w_load.status        = status_in;
        w_load.wb_en         = wb_en_in    & valid_in;
        w_load.mem_r_en      = mem_r_en_in & valid_in;
        w_load.mem_w_en      = mem_w_en_in & valid_in;
        w_load.b             = b_in        & valid_in;
        w_load.s             = s_in        & valid_in;
        w_load.is_ldr_or_str = (mem_r_en_in | mem_w_en_in) & valid_in;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else if (flush) begin
            r_stage <= '0;
        end else if (!freeze) begin
            r_stage <= w_load;
        end
    end

`ifdef FORWARDING_EN
    logic [3:0] r_src1;
    logic [3:0] r_src2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (flush) begin
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (!freeze) begin
            r_src1 <= src1_in;
            r_src2 <= src2_in;
        end
    end

    assign src1_out = r_src1;
    assign src2_out = r_src2;
`else
    logic w_unused_src;
    assign w_unused_src = ^{src1_in, src2_in};
    assign src1_out     = 4'h0;
    assign src2_out     = 4'h0;
`endif

    assign valid_out         = r_stage.valid;
    assign pc_out            = r_stage.pc;
    assign val_rn_out        = r_stage.val_rn;
    assign val_rm_out        = r_stage.val_rm;
    assign imm_out           = r_stage.imm;
    assign shift_operand_out = r_stage.shift_operand;
    assign signed_imm_24_out = r_stage.signed_imm_24;
    assign dest_out          = r_stage.dest;
    assign exe_cmd_out       = r_stage.exe_cmd;
    assign status_out        = r_stage.status;
    assign wb_en_out         = r_stage.wb_en;
    assign mem_r_en_out      = r_stage.mem_r_en;
    assign mem_w_en_out      = r_stage.mem_w_en;
    assign b_out             = r_stage.b;
    assign s_out             = r_stage.s;
    assign is_ldr_or_str_out = r_stage.is_ldr_or_str;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: the driver queues expected outputs, a monitor compares each cycle.
module tb_id_exe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic [3:0]  status;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic [3:0]  status;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        ldst;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n, freeze, flush;
    in_t         drv;
    logic        valid_out, imm_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic        is_ldr_or_str_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, exe_cmd_out, status_out, src1_out, src2_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    out_t exp_q[$];
    out_t model;

    always #5 clk = ~clk;

    id_exe_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(drv.valid), .pc_in(drv.pc), .val_rn_in(drv.val_rn), .val_rm_in(drv.val_rm),
        .imm_in(drv.imm), .shift_operand_in(drv.shift_operand), .signed_imm_24_in(drv.signed_imm_24),
        .dest_in(drv.dest), .exe_cmd_in(drv.exe_cmd), .status_in(drv.status),
        .src1_in(drv.src1), .src2_in(drv.src2), .wb_en_in(drv.wb_en), .mem_r_en_in(drv.mem_r_en),
        .mem_w_en_in(drv.mem_w_en), .b_in(drv.b), .s_in(drv.s),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .exe_cmd_out(exe_cmd_out), .status_out(status_out),
        .src1_out(src1_out), .src2_out(src2_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .is_ldr_or_str_out(is_ldr_or_str_out)
    );

    function automatic out_t snap();
        return {valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                signed_imm_24_out, dest_out, exe_cmd_out, status_out, src1_out, src2_out,
                wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, is_ldr_or_str_out};
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Expected contents after one edge, given the inputs applied before it.
    function automatic out_t next_state(out_t cur, in_t v, logic fl, logic fz, logic rs);
        out_t n;
        if (!rs || fl) return '0;
        if (fz) return cur;
        n = '0;
        n.valid         = v.valid;
        n.pc            = v.pc;
        n.val_rn        = v.val_rn;
        n.val_rm        = v.val_rm;
        n.imm           = v.imm;
        n.shift_operand = v.shift_operand;
        n.signed_imm_24 = v.signed_imm_24;
        n.dest          = v.dest;
        n.exe_cmd       = v.exe_cmd;
        n.status        = v.status;
`ifdef FORWARDING_EN
        n.src1          = v.src1;
        n.src2          = v.src2;
`endif
        n.wb_en         = v.valid & v.wb_en;
        n.mem_r_en      = v.valid & v.mem_r_en;
        n.mem_w_en      = v.valid & v.mem_w_en;
        n.b             = v.valid & v.b;
        n.s             = v.valid & v.s;
        n.ldst          = v.valid & (v.mem_r_en | v.mem_w_en);
        return n;
    endfunction

    task automatic apply(input in_t v, input logic fl, input logic fz, input logic rs);
        @(negedge clk);
        #1;
        drv    = v;
        flush  = fl;
        freeze = fz;
        rst_n  = rs;
        model  = next_state(model, v, fl, fz, rs);
        exp_q.push_back(model);
    endtask

    // Pull rst_n low between edges and confirm outputs clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (snap() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %h, required all zero", snap());
        end
        model = '0;
    endtask

    initial begin : monitor
        out_t e, got;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = snap();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle %0d: outputs %h, required %h", cycle, got, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        in_t v;
        model  = '0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
        drv    = rand_in();

        // Reset held with random inputs: outputs must be zero.
        apply(rand_in(), 1'b0, 1'b0, 1'b0);
        apply(rand_in(), 1'b0, 1'b0, 1'b0);

        v = '0; v.valid = 1'b1; v.pc = 32'h0000_0004; v.val_rm = 32'hDEAD_BEEF;
        apply(v, 1'b0, 1'b0, 1'b1);

        // Load/store flag, valid and not valid.
        v = '0; v.valid = 1'b1; v.mem_r_en = 1'b1; v.shift_operand = 12'hFFC;
        apply(v, 1'b0, 1'b0, 1'b1);
        v.valid = 1'b0;
        apply(v, 1'b0, 1'b0, 1'b1);
        v = '0; v.valid = 1'b1; v.mem_w_en = 1'b1; v.wb_en = 1'b1; v.b = 1'b1; v.s = 1'b1;
        apply(v, 1'b0, 1'b0, 1'b1);

        // Freeze for three cycles while exe_cmd_in changes.
        v = '0; v.valid = 1'b1; v.exe_cmd = 4'b0100; v.pc = 32'h0000_0100;
        apply(v, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            v.exe_cmd = 4'(i);
            apply(v, 1'b0, 1'b1, 1'b1);
        end
        v.exe_cmd = 4'b1001;
        apply(v, 1'b0, 1'b0, 1'b1);

        // Flush beats freeze, then back-to-back flushes give one bubble each.
        v = '0; v.valid = 1'b1; v.wb_en = 1'b1; v.dest = 4'hA;
        apply(v, 1'b0, 1'b0, 1'b1);
        apply(rand_in(), 1'b1, 1'b1, 1'b1);
        apply(rand_in(), 1'b1, 1'b0, 1'b1);
        apply(rand_in(), 1'b0, 1'b1, 1'b1);

        // Source register numbers for forwarding.
        v = '0; v.valid = 1'b1; v.src1 = 4'h3; v.src2 = 4'h7; v.signed_imm_24 = 24'h80_0001;
        apply(v, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            apply(rand_in(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b1);
        end

        // Async reset while a valid instruction is held.
        v = rand_in(); v.valid = 1'b1;
        apply(v, 1'b0, 1'b0, 1'b1);
        async_reset();
        apply(rand_in(), 1'b0, 1'b0, 1'b0);
        apply(rand_in(), 1'b0, 1'b0, 1'b1);

        // Async reset during freeze: outputs stay zero until the next load.
        v = rand_in(); v.valid = 1'b1;
        apply(v, 1'b0, 1'b0, 1'b1);
        apply(rand_in(), 1'b0, 1'b1, 1'b1);
        async_reset();
        apply(rand_in(), 1'b0, 1'b1, 1'b0);
        apply(rand_in(), 1'b0, 1'b1, 1'b1);
        apply(rand_in(), 1'b0, 1'b1, 1'b1);
        v = rand_in(); v.valid = 1'b1; v.mem_r_en = 1'b1;
        apply(v, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
